button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 102 ++++++++++
 rtl/button_conditioner.sv | 72 +++++++
 tb/tb_button_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and channel state type for the button/switch conditioner
package button_pkg;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_HIT    = 1;
  localparam int BTN_STAND  = 2;
  localparam int BTN_DOUBLE = 3;
  localparam int BTN_GRESET = 4;

  localparam int SW_BET1  = 0;
  localparam int SW_BET2  = 1;
  localparam int SW_BET4  = 2;
  localparam int SW_BET8  = 3;
  localparam int SW_SPLIT = 4;

  // 10 ms of stability at 100 MHz
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } chan_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input channel: synchronizer plus debounce FSM with saturating counter
module debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit PULSE_EN        = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse,
  output logic o_level_change
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  chan_state_t            r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   w_sync;
  logic                   w_accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // High on the edge where a wait state commits to the new level
  assign w_accept = (r_cnt == CNT_MAX) &&
                    (((r_state == PRESS_WAIT) && w_sync) ||
                     ((r_state == RELEASE_WAIT) && !w_sync));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_sync) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_pulse <= PULSE_EN;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_sync) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (w_sync) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level        = r_level;
  assign o_pulse        = r_pulse;
  assign o_level_change = w_accept;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced buttons/switches, press pulses and bet value for the game top
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 5,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_stable,
  output logic [3:0]       bet_value,
  output logic             sw_change
);

  logic [N_BTN-1:0] w_btn_change;
  logic [N_SW-1:0]  w_sw_change;
  logic [N_SW-1:0]  w_sw_pulse;
  logic             w_unused_ok;
  logic             r_sw_change;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_EN       (1'b1)
    ) u_chan (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_raw         (btn_raw[i]),
      .o_level       (btn_level[i]),
      .o_pulse       (btn_pulse[i]),
      .o_level_change(w_btn_change[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_EN       (1'b0)
    ) u_chan (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_raw         (sw_raw[i]),
      .o_level       (sw_stable[i]),
      .o_pulse       (w_sw_pulse[i]),
      .o_level_change(w_sw_change[i])
    );
  end

  // Button edges are reported through btn_pulse; switch pulses are tied off inside the channel
  assign w_unused_ok = &{1'b0, w_btn_change, w_sw_pulse};

  // Registered so sw_change lines up with the sw_stable update it reports
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_change <= 1'b0;
    end else begin
      r_sw_change <= |w_sw_change;
    end
  end

  assign sw_change = r_sw_change;
  assign bet_value = sw_stable[SW_BET8:SW_BET1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with directed vectors
module tb_button_conditioner;
  import button_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] sw_raw = '0;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic [4:0] sw_stable;
  logic [3:0] bet_value;
  logic       sw_change;

  button_conditioner #(
    .N_BTN(5), .N_SW(5), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_stable(sw_stable),
    .bet_value(bet_value), .sw_change(sw_change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [4:0] pulse;
    logic       chg;
    logic [4:0] lvl;
    logic [4:0] sws;
    logic [3:0] bet;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic expect_evt(int at, logic [4:0] p, logic c, logic [4:0] l,
                            logic [4:0] s, logic [3:0] b);
    exp_t e;
    e.at = at; e.pulse = p; e.chg = c; e.lvl = l; e.sws = s; e.bet = b;
    q.push_back(e);
  endtask

  // Monitor: every pulse-type output must match the next scoreboard entry
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && (btn_pulse != 5'b0 || sw_change)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {26'b0, btn_pulse, sw_change}, 32'b0);
      end else begin
        e = q.pop_front();
        chk("evt_cycle", cyc, e.at);
        chk("evt_btn_pulse", btn_pulse, e.pulse);
        chk("evt_sw_change", sw_change, e.chg);
        chk("evt_btn_level", btn_level, e.lvl);
        chk("evt_sw_stable", sw_stable, e.sws);
        chk("evt_bet_value", bet_value, e.bet);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_btn_level"}, btn_level, 0);
    chk({tag, "_btn_pulse"}, btn_pulse, 0);
    chk({tag, "_sw_stable"}, sw_stable, 0);
    chk({tag, "_bet_value"}, bet_value, 0);
    chk({tag, "_sw_change"}, sw_change, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Clean press on HIT, then release
    k = cyc + 1;
    btn_raw[BTN_HIT] = 1'b1;
    expect_evt(k + LAT, 5'b00010, 1'b0, 5'b00010, 5'b0, 4'd0);
    wait_edge(k + LAT - 1);
    chk("hit_level_before", btn_level, 0);
    wait_edge(k + LAT + 1);
    chk("hit_level_held", btn_level, 5'b00010);
    wait_edge(k + 20);
    chk("hit_level_long_hold", btn_level, 5'b00010);
    k = cyc + 1;
    btn_raw = '0;
    wait_edge(k + LAT - 1);
    chk("hit_release_before", btn_level, 5'b00010);
    wait_edge(k + LAT);
    chk("hit_release_after", btn_level, 0);
    tick(4);

    // Bounce on NEXT, then a solid press
    btn_raw[BTN_NEXT] = 1'b1; tick(2);
    btn_raw[BTN_NEXT] = 1'b0; tick(2);
    btn_raw[BTN_NEXT] = 1'b1; tick(2);
    btn_raw[BTN_NEXT] = 1'b0; tick(2);
    k = cyc + 1;
    btn_raw[BTN_NEXT] = 1'b1;
    expect_evt(k + LAT, 5'b00001, 1'b0, 5'b00001, 5'b0, 4'd0);
    wait_edge(k + LAT - 1);
    chk("bounce_level_before", btn_level, 0);
    wait_edge(k + LAT + 4);

    // Short release glitch is ignored, long release is accepted
    btn_raw[BTN_NEXT] = 1'b0; tick(2);
    btn_raw[BTN_NEXT] = 1'b1; tick(10);
    chk("glitch_level_kept", btn_level, 5'b00001);
    k = cyc + 1;
    btn_raw[BTN_NEXT] = 1'b0;
    wait_edge(k + LAT - 1);
    chk("drop_level_before", btn_level, 5'b00001);
    wait_edge(k + LAT);
    chk("drop_level_after", btn_level, 0);
    tick(4);

    // Switches: bet 11, then bet_8 off -> 3
    k = cyc + 1;
    sw_raw = 5'b01011;
    expect_evt(k + LAT, 5'b0, 1'b1, 5'b0, 5'b01011, 4'd11);
    wait_edge(k + LAT + 4);
    chk("bet_11_stable", bet_value, 4'd11);
    k = cyc + 1;
    sw_raw[SW_BET8] = 1'b0;
    expect_evt(k + LAT, 5'b0, 1'b1, 5'b0, 5'b00011, 4'd3);
    wait_edge(k + LAT + 4);

    // Simultaneous STAND and DOUBLE
    k = cyc + 1;
    btn_raw = 5'b01100;
    expect_evt(k + LAT, 5'b01100, 1'b0, 5'b01100, 5'b00011, 4'd3);
    wait_edge(k + LAT + 4);
    btn_raw = '0;
    tick(LAT + 4);

    // Game-reset button is a plain output
    k = cyc + 1;
    btn_raw[BTN_GRESET] = 1'b1;
    expect_evt(k + LAT, 5'b10000, 1'b0, 5'b10000, 5'b00011, 4'd3);
    wait_edge(k + LAT + 4);
    chk("greset_level_held", btn_level, 5'b10000);
    chk("greset_switches_kept", sw_stable, 5'b00011);
    btn_raw = '0;
    tick(LAT + 4);

    // Zero bet is legal
    k = cyc + 1;
    sw_raw = '0;
    expect_evt(k + LAT, 5'b0, 1'b1, 5'b0, 5'b0, 4'd0);
    wait_edge(k + LAT + 4);

    // Reset while NEXT is pending, button held through reset release
    btn_raw[BTN_NEXT] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk_all_zero("midreset");
    reset = 1'b0;
    k = cyc + 1;
    expect_evt(k + LAT, 5'b00001, 1'b0, 5'b00001, 5'b0, 4'd0);
    wait_edge(k + LAT - 1);
    chk("midreset_level_before", btn_level, 0);
    wait_edge(k + LAT + 4);
    btn_raw = '0;
    tick(LAT + 4);

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
